// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encoding, ACK/NACK levels and the R/W bit position.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic        I2C_ACK  = 1'b0;
  localparam logic        I2C_NACK = 1'b1;
  localparam int unsigned RW_BIT   = 0;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchronizer followed by a FILTER_LEN-sample glitch filter.
// A new level is accepted only after FILTER_LEN consecutive agreeing samples; rise/fall pulse with it.
module i2c_sync_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, rise_q, fall_q;
  logic [CW-1:0] cnt_q;
  logic          accept;

  // cnt_q counts samples already seen disagreeing; the current one makes FILTER_LEN
  assign accept = (sync2_q != level_q) && (cnt_q == CW'(FILTER_LEN - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      rise_q  <= accept && sync2_q;
      fall_q  <= accept && !sync2_q;
      if (accept) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else if (sync2_q != level_q) begin
        cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target engine: decodes START/STOP and its 7-bit address, then bridges bytes onto
// a synchronous register port with an auto-incrementing 8-bit pointer.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_i,
  output logic       scl_o,
  input  logic       sda_i,
  output logic       sda_o,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  i2c_state_e state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       sda_q, sda_d;
  logic       we_q, we_d;
  logic       re_q, re_d;
  logic       cap_q;
  logic       busy_q, busy_d;
  logic       mack_q, mack_d;

  logic       scl_lvl, scl_rise, scl_fall;
  logic       sda_lvl, sda_rise, sda_fall;
  logic       start_det, stop_det;
  logic [7:0] rx_byte;

  i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk_i  (clk),
    .reset_i(reset),
    .line_i (scl_i),
    .level_o(scl_lvl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk_i  (clk),
    .reset_i(reset),
    .line_i (sda_i),
    .level_o(sda_lvl),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  assign start_det = sda_fall && scl_lvl;
  assign stop_det  = sda_rise && scl_lvl;
  assign rx_byte   = {shift_q[6:0], sda_lvl};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    sda_d     = sda_q;
    busy_d    = busy_q;
    mack_d    = mack_q;
    we_d      = 1'b0;
    re_d      = 1'b0;

    if (we_q) addr_d = addr_q + 8'd1;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_d     = I2C_NACK;
      busy_d    = 1'b1;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_d     = I2C_NACK;
      busy_d    = 1'b0;
    end else begin
      // read data lands one cycle after reg_re; MSB goes out while SCL is still low
      if (cap_q) begin
        shift_d = reg_rdata;
        sda_d   = reg_rdata[7];
      end
      case (state_q)
        ST_ADDR, ST_PTR, ST_WR: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && state_q == ST_PTR) addr_d = rx_byte;
            if (bit_cnt_q == 4'd7 && state_q == ST_WR) begin
              we_d    = 1'b1;
              wdata_d = rx_byte;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            sda_d = I2C_ACK;
            if (state_q == ST_PTR) begin
              state_d = ST_PTR_ACK;
            end else if (state_q == ST_WR) begin
              state_d = ST_WR_ACK;
            end else if (shift_q[7:1] == SLAVE_ADDR) begin
              state_d = ST_ADDR_ACK;
            end else begin
              state_d = ST_IGNORE;
              sda_d   = I2C_NACK;
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            sda_d     = I2C_NACK;
            bit_cnt_d = '0;
            if (state_q == ST_ADDR_ACK && shift_q[RW_BIT]) begin
              state_d = ST_RD;
              re_d    = 1'b1;
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WR;
            end
          end
        end
        ST_RD: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d = ST_RD_ACK;
            sda_d   = I2C_NACK;
          end else if (scl_fall && bit_cnt_q != 4'd0) begin
            shift_d = {shift_q[6:0], 1'b0};
            sda_d   = shift_q[6];
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            mack_d = sda_lvl;
          end else if (scl_fall) begin
            bit_cnt_d = '0;
            if (mack_q == I2C_ACK) begin
              state_d = ST_RD;
              addr_d  = addr_q + 8'd1;
              re_d    = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      sda_q     <= 1'b1;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      cap_q     <= 1'b0;
      busy_q    <= 1'b0;
      mack_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      sda_q     <= sda_d;
      we_q      <= we_d;
      re_q      <= re_d;
      cap_q     <= re_q;
      busy_q    <= busy_d;
      mack_q    <= mack_d;
    end
  end

  assign scl_o     = 1'b1;
  assign sda_o     = sda_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bus-level master drives directed and random transactions; expected
// register writes, reads and SDA bytes come from transaction-level rules and a bench memory.
module tb_i2c_target;

  localparam int unsigned Q = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic       scl_o, sda_o;
  logic       scl_line, sda_line;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic       reg_we, reg_re, busy;

  logic [7:0] rmem [256];
  logic [7:0] wbuf [8];
  logic [7:0] we_a [$];
  logic [7:0] we_d [$];
  logic [7:0] re_a [$];
  int         checks = 0;
  int         failures = 0;
  int         dbl_we = 0, dbl_re = 0, hold_viol = 0;
  logic       prev_we = 1'b0, prev_re = 1'b0;

  always #5 clk = ~clk;

  assign scl_line  = scl_m & scl_o;
  assign sda_line  = sda_m & sda_o;
  assign reg_rdata = rmem[reg_addr];

  i2c_target #(.SLAVE_ADDR(7'h50), .FILTER_LEN(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_line),
    .scl_o    (scl_o),
    .sda_i    (sda_line),
    .sda_o    (sda_o),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (reg_we) begin
      we_a.push_back(reg_addr);
      we_d.push_back(reg_wdata);
    end
    if (reg_re) re_a.push_back(reg_addr);
    if (reg_we && prev_we) dbl_we++;
    if (reg_re && prev_re) dbl_re++;
    prev_we = reg_we;
    prev_re = reg_re;
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    we_a.delete();
    we_d.delete();
    re_a.delete();
  endtask

  task automatic send_bit(input logic b, output logic smp);
    logic s2;
    sda_m = b;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    smp = sda_line;
    cyc(Q - 1);
    s2 = sda_line;
    if (s2 !== smp) hold_viol++;
    cyc(1);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) send_bit(b[i], d);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, d);
      b[i] = d;
    end
    send_bit(mack, d);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b0;
    cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    cyc(Q);
    scl_m = 1'b1;
    cyc(Q);
    sda_m = 1'b1;
    cyc(2 * Q);
  endtask

  // START, 0xA0, ptr, n bytes from wbuf, STOP; writes must land at ptr, ptr+1, ... mod 256
  task automatic write_burst(input string tag, input logic [7:0] ptr, input int n);
    logic ack;
    clear_logs();
    i2c_start();
    chk({tag, "_busy_hi"}, busy, 1);
    send_byte(8'hA0, ack);
    chk({tag, "_addr_ack"}, ack, 0);
    send_byte(ptr, ack);
    chk({tag, "_ptr_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      send_byte(wbuf[i], ack);
      chk({tag, "_data_ack"}, ack, 0);
    end
    i2c_stop();
    chk({tag, "_busy_lo"}, busy, 0);
    chk({tag, "_we_count"}, we_a.size(), n);
    chk({tag, "_re_count"}, re_a.size(), 0);
    for (int i = 0; i < n && i < we_a.size(); i++) begin
      chk({tag, "_we_addr"}, we_a[i], 8'(ptr + 8'(i)));
      chk({tag, "_we_data"}, we_d[i], wbuf[i]);
    end
  endtask

  // START, 0xA0, ptr, Sr, 0xA1, read n bytes (ACK all but last), STOP
  task automatic read_burst(input string tag, input logic [7:0] ptr, input int n);
    logic       ack;
    logic [7:0] b;
    clear_logs();
    i2c_start();
    send_byte(8'hA0, ack);
    chk({tag, "_addr_ack"}, ack, 0);
    send_byte(ptr, ack);
    chk({tag, "_ptr_ack"}, ack, 0);
    i2c_start();
    send_byte(8'hA1, ack);
    chk({tag, "_raddr_ack"}, ack, 0);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1), b);
      chk({tag, "_rd_byte"}, b, rmem[8'(ptr + 8'(i))]);
    end
    i2c_stop();
    chk({tag, "_busy_lo"}, busy, 0);
    chk({tag, "_we_count"}, we_a.size(), 0);
    chk({tag, "_re_count"}, re_a.size(), n);
    for (int i = 0; i < n && i < re_a.size(); i++)
      chk({tag, "_re_addr"}, re_a[i], 8'(ptr + 8'(i)));
    chk({tag, "_ptr_end"}, reg_addr, 8'(ptr + 8'(n - 1)));
  endtask

  // Foreign address: no ACK anywhere, no strobes, pointer untouched
  task automatic mismatch(input string tag, input logic [7:0] addr_byte, input logic [7:0] data);
    logic       ack;
    logic [7:0] ptr_before;
    ptr_before = reg_addr;
    clear_logs();
    i2c_start();
    send_byte(addr_byte, ack);
    chk({tag, "_addr_nack"}, ack, 1);
    send_byte(data, ack);
    chk({tag, "_data_nack"}, ack, 1);
    i2c_stop();
    chk({tag, "_we_count"}, we_a.size(), 0);
    chk({tag, "_re_count"}, re_a.size(), 0);
    chk({tag, "_ptr_same"}, reg_addr, ptr_before);
  endtask

  initial begin
    logic       ack, d;
    logic [7:0] ptr, b, a7;
    int         n;

    for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
    scl_m = 1'b1;
    sda_m = 1'b1;
    reset = 1'b1;
    cyc(4);
    reset = 1'b0;
    cyc(2);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_scl_o", scl_o, 1);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_busy", busy, 0);

    wbuf[0] = 8'hA5;
    wbuf[1] = 8'h3C;
    write_burst("wr_burst", 8'h10, 2);

    mismatch("mismatch", 8'hA2, 8'h10);

    rmem[8'h20] = 8'h5A;
    rmem[8'h21] = 8'hC3;
    read_burst("rand_read", 8'h20, 2);

    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    write_burst("ptr_wrap", 8'hFF, 2);

    // STOP after 4 data bits: partial byte dropped
    clear_logs();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h44, ack);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), d);
    i2c_stop();
    chk("abort_we_count", we_a.size(), 0);
    chk("abort_busy", busy, 0);
    chk("abort_ptr", reg_addr, 8'h44);

    // 1-cycle SCL glitch mid-byte must not be counted as a bit
    clear_logs();
    b = 8'($urandom);
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h60, ack);
    for (int i = 7; i >= 4; i--) send_bit(b[i], d);
    sda_m = b[3];
    cyc(Q);
    scl_m = 1'b1;
    cyc(1);
    scl_m = 1'b0;
    cyc(Q);
    for (int i = 3; i >= 0; i--) send_bit(b[i], d);
    send_bit(1'b1, ack);
    chk("glitch_ack", ack, 0);
    i2c_stop();
    chk("glitch_we_count", we_a.size(), 1);
    if (we_a.size() > 0) begin
      chk("glitch_we_addr", we_a[0], 8'h60);
      chk("glitch_we_data", we_d[0], b);
    end

    // Reset while the target holds ACK low
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h30, ack);
    for (int i = 7; i >= 0; i--) send_bit(1'($urandom), d);
    sda_m = 1'b1;
    chk("rstack_driven", sda_o, 0);
    reset = 1'b1;
    cyc(1);
    chk("rstack_sda_rel", sda_o, 1);
    chk("rstack_busy", busy, 0);
    chk("rstack_addr", reg_addr, 8'h00);
    reset = 1'b0;
    cyc(Q);
    scl_m = 1'b1;
    cyc(2 * Q);
    scl_m = 1'b0;
    cyc(Q);
    clear_logs();
    send_byte(8'hA0, ack);
    send_byte(8'h55, ack);
    chk("rstack_noack", ack, 1);
    chk("rstack_we_count", we_a.size(), 0);
    sda_m = 1'b1;
    scl_m = 1'b1;
    cyc(2 * Q);

    for (int t = 0; t < 4; t++) begin
      ptr = 8'($urandom);
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      write_burst("rnd_wr", ptr, n);
      ptr = 8'($urandom);
      read_burst("rnd_rd", ptr, int'($urandom_range(1, 3)));
      do a7 = 8'($urandom_range(0, 127)); while (a7 == 8'h50);
      mismatch("rnd_mis", {a7[6:0], 1'($urandom)}, 8'($urandom));
    end

    chk("we_single_cycle", dbl_we, 0);
    chk("re_single_cycle", dbl_re, 0);
    chk("sda_hold_scl_high", hold_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
